sm83_timer: RTL and testbench
=============================

// Module: sm83_timer
// PURPOSE
//  Memory-mapped timer peripheral; bus responder on the SM83 CPU data/address bus.
//  Decodes DIV/TIMA/TMA/TAC at BASE_ADR..BASE_ADR+3 and serves CPU rd/wr cycles.
//  Counts a 16-bit divider on every T-cycle tick and raises one interrupt request
//  line into the CPU irq vector on TIMA overflow. The request is held until the CPU acknowledges it on iack.
// PARAMETERS
//  BASE_ADR   16'hff04  address of DIV; TIMA=+1, TMA=+2, TAC=+3
//  RELOAD_DLY 4         ticks TIMA stays 8'h00 before TMA reload + irq (only with delay feature)
// PORTS
//  clk     in   1   system clock, all state on rising edge
//  nreset  in   1   synchronous reset, active low
//  tick    in   1   T-cycle enable; counters advance only on cycles with tick=1
//  adr     in   16  CPU address bus
//  din     in   8   CPU write data (CPU dout)
//  dout    out  8   read data to CPU din mux
//  sel     out  1   adr in BASE_ADR..BASE_ADR+3; steers CPU din mux
//  rd      in   1   CPU read strobe
//  wr      in   1   CPU write strobe
//  irq     out  1   timer interrupt request (level)
//  iack    in   1   CPU acknowledge for this irq bit
// BEHAVIOUR
//  Reset (nreset=0 at clk edge): div=16'h0000, tima=0, tma=0, tac=3'b000, irq=0, ovf_cnt=0.
//  sel/dout combinational: dout = reg when sel&&rd, else 8'hff.
//  Reads: DIV->div[15:8]; TIMA->tima; TMA->tma; TAC->{5'b11111,tac}. No read side effects.
//  Writes: taken on every clk edge with wr&&sel; repeated edges of one bus cycle are idempotent.
//   DIV: any value -> div=0. TIMA: tima=din. TMA: tma=din. TAC: tac=din[2:0].
//  Divider: div+1 on each tick, wraps 16'hffff->0. A DIV write on the same edge as tick wins (div=0).
//  Timer input t_in = tac[2] & div[b], b = {9,3,5,7}[tac[1:0]] (1024/16/64/256 ticks).
//  t_in_q registered each clk; falling edge (t_in_q & !t_in) increments tima.
//   Consequence: DIV write or TAC change that drops t_in from 1 to 0 also increments (hw-accurate).
//  Overflow: increment of 8'hff -> tima=8'h00, see CONFIGURATION for reload.
//  Reload: tima<=tma; irq<=1. TMA write on the reload edge: new din value is loaded.
//  irq: set on reload; cleared on iack edge. Set and iack on same edge -> irq stays 1.
//  Write to TIMA and overflow-increment on same edge: CPU write wins, no overflow.
// CONFIGURATION
//  TIMER_RELOAD_DELAY_EN defined:
//   Overflow starts ovf_cnt=RELOAD_DLY; counts down per tick while tima reads 8'h00.
//   ovf_cnt reaching 0 -> reload + irq on that edge. TIMA write while ovf_cnt!=0
//   cancels pending reload and irq (ovf_cnt=0, tima=din). Reset mid-delay clears it.
//  Not defined: reload tima<=tma and irq<=1 on the same edge as the overflow; ovf_cnt absent.
// TESTING
//  1 reset then 1024 ticks, read DIV -> 8'h04; write DIV 8'h5a -> next read 8'h00.
//  2 TAC=3'b101, TIMA=8'hfe, TMA=8'h80, 32 ticks -> TIMA 8'hff then overflow; irq=1,
//    TIMA=8'h80 (delay EN: TIMA=00 for 4 ticks first).
//  3 irq=1, pulse iack one cycle -> irq=0; iack coincident with new reload -> irq=1.
//  4 delay EN: write TIMA=8'h33 two ticks after overflow -> TIMA=8'h33, irq stays 0, no reload.
//  5 TAC=3'b101, run until div[3]=1, write DIV -> TIMA increments by exactly 1.
//  6 read adr BASE_ADR+3 after reset -> dout=8'hf8, sel=1; adr BASE_ADR+4 -> sel=0, dout=8'hff.

Source files
------------

// File: rtl/sm83_timer.sv
// sm83_timer: memory-mapped DIV/TIMA/TMA/TAC timer for the SM83 CPU bus.
// The registers sit at BASE_ADR..BASE_ADR+3. irq is a level that stays high
// until the CPU acknowledges it on iack.
// Optional feature: define TIMER_RELOAD_DELAY_EN to hold TIMA at 8'h00 for
// RELOAD_DLY ticks after an overflow before the TMA reload and irq.
module sm83_timer #(
  parameter logic [15:0] BASE_ADR   = 16'hff04,
  parameter int          RELOAD_DLY = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        tick,
  input  logic [15:0] adr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        sel,
  input  logic        rd,
  input  logic        wr,
  output logic        irq,
  input  logic        iack
);

  logic [15:0] div;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic        t_in;
  logic        t_in_q;
  logic        tima_inc;
  logic        reload;
  logic [15:0] offset;
  logic        wr_div;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;
  logic [7:0]  tma_next;

  // The window is found by offset from the base, so any base alignment works.
  assign offset   = adr - BASE_ADR;
  assign sel      = (offset[15:2] == 14'd0);
  assign wr_div   = wr && sel && (offset[1:0] == 2'd0);
  assign wr_tima  = wr && sel && (offset[1:0] == 2'd1);
  assign wr_tma   = wr && sel && (offset[1:0] == 2'd2);
  assign wr_tac   = wr && sel && (offset[1:0] == 2'd3);
  // A TMA write that lands on the reload edge reloads the freshly written value.
  assign tma_next = wr_tma ? din : tma;
  assign tima_inc = t_in_q & ~t_in;

  // Select the divider tap that clocks TIMA; a disabled timer holds t_in low.
  always_comb begin
    t_in = 1'b0;
    case (tac[1:0])
      2'd0:    t_in = div[9];
      2'd1:    t_in = div[3];
      2'd2:    t_in = div[5];
      default: t_in = div[7];
    endcase
    t_in = t_in & tac[2];
  end

  // The read mux drives 8'hff whenever this peripheral is not being read.
  always_comb begin
    dout = 8'hff;
    if (sel && rd) begin
      case (offset[1:0])
        2'd0:    dout = div[15:8];
        2'd1:    dout = tima;
        2'd2:    dout = tma;
        default: dout = {5'b11111, tac};
      endcase
    end
  end

  // The divider advances on each tick, and any DIV write clears it even on a tick edge.
  always_ff @(posedge clk) begin
    if (!nreset)
      div <= 16'h0000;
    else if (wr_div)
      div <= 16'h0000;
    else if (tick)
      div <= div + 16'd1;
  end

  // TMA and TAC are plain CPU-written registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      tma <= 8'h00;
      tac <= 3'b000;
    end else begin
      if (wr_tma)
        tma <= din;
      if (wr_tac)
        tac <= din[2:0];
    end
  end

  // t_in is sampled on every clock so that a falling edge caused by DIV or TAC writes also counts.
  always_ff @(posedge clk) begin
    if (!nreset)
      t_in_q <= 1'b0;
    else
      t_in_q <= t_in;
  end

`ifdef TIMER_RELOAD_DELAY_EN
  localparam int CW = $clog2(RELOAD_DLY + 1);
  logic [CW-1:0] ovf_cnt;

  // The reload fires on the tick that brings the pending delay down to zero.
  assign reload = !wr_tima && tick && (ovf_cnt == CW'(1));

  // While a reload is pending, TIMA holds 8'h00 and ignores further increments.
  // A CPU write to TIMA cancels the pending reload.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      tima    <= 8'h00;
      ovf_cnt <= '0;
    end else if (wr_tima) begin
      tima    <= din;
      ovf_cnt <= '0;
    end else if (ovf_cnt != '0) begin
      if (tick)
        ovf_cnt <= ovf_cnt - CW'(1);
      if (reload)
        tima <= tma_next;
    end else if (tima_inc) begin
      tima <= tima + 8'd1;
      if (tima == 8'hff)
        ovf_cnt <= CW'(RELOAD_DLY);
    end
  end
`else
  // The reload happens on the same edge as the overflowing increment.
  assign reload = !wr_tima && tima_inc && (tima == 8'hff);

  // A CPU write to TIMA beats both the increment and the reload.
  always_ff @(posedge clk) begin
    if (!nreset)
      tima <= 8'h00;
    else if (wr_tima)
      tima <= din;
    else if (reload)
      tima <= tma_next;
    else if (tima_inc)
      tima <= tima + 8'd1;
  end
`endif

  // The interrupt request is set on reload and cleared on acknowledge; a new reload beats iack.
  always_ff @(posedge clk) begin
    if (!nreset)
      irq <= 1'b0;
    else if (reload)
      irq <= 1'b1;
    else if (iack)
      irq <= 1'b0;
  end

endmodule

// File: tb/tb_sm83_timer.sv
// tb_sm83_timer: directed scenarios plus a randomized run checked against an
// integer-arithmetic reference model of the timer.
module tb_sm83_timer;

  localparam logic [15:0] BASE = 16'hff04;
`ifdef TIMER_RELOAD_DELAY_EN
  localparam int DLY = 4;
`else
  localparam int DLY = 0;
`endif

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] adr = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic        iack = 1'b0;
  logic [7:0]  dout;
  logic        sel;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, kept as plain integers.
  int m_div = 0, m_tima = 0, m_tma = 0, m_tac = 0, m_irq = 0, m_tinq = 0, m_ovf = 0;
  int tap [4] = '{9, 3, 5, 7};

  sm83_timer #(.BASE_ADR(BASE), .RELOAD_DLY(4)) dut (
    .clk(clk), .nreset(nreset), .tick(tick), .adr(adr), .din(din),
    .dout(dout), .sel(sel), .rd(rd), .wr(wr), .irq(irq), .iack(iack)
  );

  always #5 clk = ~clk;

  function automatic bit m_sel(input logic [15:0] a);
    int o;
    o = int'(a) - int'(BASE);
    return (o >= 0) && (o <= 3);
  endfunction

  function automatic int m_dout(input logic [15:0] a, input logic r);
    int o;
    o = int'(a) - int'(BASE);
    if (!(m_sel(a) && r)) return 255;
    case (o)
      0: return (m_div / 256) % 256;
      1: return m_tima;
      2: return m_tma;
      default: return 248 + m_tac;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs the bench is driving.
  task automatic m_step();
    int o, t_in, fall, reload, n_div, n_tima, n_tma, n_tac, n_ovf;
    bit w;
    if (!nreset) begin
      m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_irq = 0; m_tinq = 0; m_ovf = 0;
      return;
    end
    o = int'(adr) - int'(BASE);
    w = wr && (o >= 0) && (o <= 3);
    t_in = (m_tac >= 4) ? ((m_div >> tap[m_tac % 4]) & 1) : 0;
    fall = (m_tinq == 1 && t_in == 0) ? 1 : 0;
    n_tma = (w && o == 2) ? int'(din) : m_tma;
    n_tac = (w && o == 3) ? int'(din) % 8 : m_tac;
    n_div = (w && o == 0) ? 0 : (tick ? (m_div + 1) % 65536 : m_div);
    n_tima = m_tima;
    n_ovf = m_ovf;
    reload = 0;
    if (w && o == 1) begin
      n_tima = int'(din);
      n_ovf = 0;
    end else if (DLY > 0 && m_ovf > 0) begin
      if (tick) begin
        n_ovf = m_ovf - 1;
        if (n_ovf == 0) begin
          n_tima = n_tma;
          reload = 1;
        end
      end
    end else if (fall == 1) begin
      if (m_tima == 255) begin
        if (DLY == 0) begin
          n_tima = n_tma;
          reload = 1;
        end else begin
          n_tima = 0;
          n_ovf = DLY;
        end
      end else begin
        n_tima = m_tima + 1;
      end
    end
    if (reload == 1) m_irq = 1;
    else if (iack) m_irq = 0;
    m_div = n_div; m_tima = n_tima; m_tma = n_tma; m_tac = n_tac; m_ovf = n_ovf;
    m_tinq = t_in;
  endtask

  // One clock: inputs are stable across the rising edge, and control returns on the falling edge.
  task automatic step();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic write_reg(input int off, input logic [7:0] v);
    adr = BASE + 16'(off);
    din = v;
    wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic read_reg(input int off, output logic [7:0] v);
    adr = BASE + 16'(off);
    rd = 1'b1;
    #1;
    v = dout;
    rd = 1'b0;
  endtask

  task automatic do_reset();
    tick = 1'b0; wr = 1'b0; rd = 1'b0; iack = 1'b0;
    nreset = 1'b0;
    step();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    read_reg(0, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("[TB] FAIL reset_div: got %h expected 00", v); end
    read_reg(1, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("[TB] FAIL reset_tima: got %h expected 00", v); end
    read_reg(2, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("[TB] FAIL reset_tma: got %h expected 00", v); end
    read_reg(3, v);
    n_cmp++; if (v !== 8'hf8) begin n_err++; $display("[TB] FAIL reset_tac: got %h expected f8", v); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_div();
    logic [7:0] v;
    do_reset();
    ticks(1024);
    read_reg(0, v);
    n_cmp++; if (v !== 8'h04) begin n_err++; $display("[TB] FAIL div_1024: got %h expected 04", v); end
    write_reg(0, 8'h5a);
    read_reg(0, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("[TB] FAIL div_clear: got %h expected 00", v); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    do_reset();
    write_reg(3, 8'h05);
    write_reg(1, 8'hfe);
    write_reg(2, 8'h80);
    ticks(17);
    read_reg(1, v);
    n_cmp++; if (v !== 8'hff) begin n_err++; $display("[TB] FAIL ovf_tima_ff: got %h expected ff", v); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_irq_early: got %b expected 0", irq); end
    ticks(16);
`ifdef TIMER_RELOAD_DELAY_EN
    read_reg(1, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("[TB] FAIL ovf_delay_zero: got %h expected 00", v); end
    ticks(3);
    read_reg(1, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("[TB] FAIL ovf_delay_hold: got %h expected 00", v); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_delay_irq: got %b expected 0", irq); end
    ticks(1);
`endif
    read_reg(1, v);
    n_cmp++; if (v !== 8'h80) begin n_err++; $display("[TB] FAIL ovf_reload: got %h expected 80", v); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_irq: got %b expected 1", irq); end
  endtask

  task automatic test_iack();
    logic [7:0] v;
    int reload_at;
    step();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("[TB] FAIL irq_held: got %b expected 1", irq); end
    iack = 1'b1;
    step();
    iack = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL irq_ack: got %b expected 0", irq); end
    do_reset();
    write_reg(3, 8'h05);
    write_reg(2, 8'h11);
    write_reg(1, 8'hff);
    reload_at = 17 + DLY;
    ticks(reload_at - 1);
    tick = 1'b1;
    iack = 1'b1;
    step();
    tick = 1'b0;
    iack = 1'b0;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("[TB] FAIL irq_set_beats_ack: got %b expected 1", irq); end
    read_reg(1, v);
    n_cmp++; if (v !== 8'h11) begin n_err++; $display("[TB] FAIL irq_reload_val: got %h expected 11", v); end
  endtask

  task automatic test_write_priority();
    logic [7:0] v;
    do_reset();
    write_reg(3, 8'h05);
    write_reg(2, 8'h80);
    write_reg(1, 8'hff);
    ticks(16);
    tick = 1'b1;
    write_reg(1, 8'h33);
    tick = 1'b0;
    read_reg(1, v);
    n_cmp++; if (v !== 8'h33) begin n_err++; $display("[TB] FAIL wr_beats_ovf: got %h expected 33", v); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL wr_beats_ovf_irq: got %b expected 0", irq); end
    ticks(40);
    read_reg(1, v);
    n_cmp++; if (v !== 8'h35) begin n_err++; $display("[TB] FAIL wr_then_count: got %h expected 35", v); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL wr_then_irq: got %b expected 0", irq); end
  endtask

`ifdef TIMER_RELOAD_DELAY_EN
  task automatic test_cancel();
    logic [7:0] v;
    do_reset();
    write_reg(3, 8'h05);
    write_reg(2, 8'h80);
    write_reg(1, 8'hff);
    ticks(17);
    ticks(2);
    write_reg(1, 8'h33);
    read_reg(1, v);
    n_cmp++; if (v !== 8'h33) begin n_err++; $display("[TB] FAIL cancel_tima: got %h expected 33", v); end
    ticks(6);
    read_reg(1, v);
    n_cmp++; if (v !== 8'h33) begin n_err++; $display("[TB] FAIL cancel_no_reload: got %h expected 33", v); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("[TB] FAIL cancel_irq: got %b expected 0", irq); end
  endtask
`endif

  task automatic test_div_write_edge();
    logic [7:0] v;
    do_reset();
    write_reg(3, 8'h05);
    write_reg(1, 8'h10);
    ticks(8);
    step();
    write_reg(0, 8'h00);
    step();
    read_reg(1, v);
    n_cmp++; if (v !== 8'h11) begin n_err++; $display("[TB] FAIL divwr_inc: got %h expected 11", v); end
    repeat (5) step();
    read_reg(1, v);
    n_cmp++; if (v !== 8'h11) begin n_err++; $display("[TB] FAIL divwr_once: got %h expected 11", v); end
  endtask

  task automatic test_decode();
    do_reset();
    adr = BASE + 16'd3; rd = 1'b1; #1;
    n_cmp++; if (dout !== 8'hf8) begin n_err++; $display("[TB] FAIL dec_tac_dout: got %h expected f8", dout); end
    n_cmp++; if (sel !== 1'b1) begin n_err++; $display("[TB] FAIL dec_tac_sel: got %b expected 1", sel); end
    adr = BASE + 16'd4; #1;
    n_cmp++; if (sel !== 1'b0) begin n_err++; $display("[TB] FAIL dec_out_sel: got %b expected 0", sel); end
    n_cmp++; if (dout !== 8'hff) begin n_err++; $display("[TB] FAIL dec_out_dout: got %h expected ff", dout); end
    adr = BASE - 16'd1; #1;
    n_cmp++; if (sel !== 1'b0) begin n_err++; $display("[TB] FAIL dec_below_sel: got %b expected 0", sel); end
    adr = BASE; rd = 1'b0; #1;
    n_cmp++; if (dout !== 8'hff) begin n_err++; $display("[TB] FAIL dec_nord_dout: got %h expected ff", dout); end
  endtask

  task automatic test_random();
    int exp_d;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      nreset = ($urandom_range(0, 999) != 0);
      tick = ($urandom_range(0, 3) != 0);
      adr = BASE + 16'($urandom_range(0, 5)) - 16'd1;
      rd = $urandom_range(0, 1);
      wr = ($urandom_range(0, 15) == 0);
      iack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1)
        din = 8'hfc + 8'($urandom_range(0, 3));
      else
        din = 8'($urandom);
      step();
      #1;
      exp_d = m_dout(adr, rd);
      n_cmp++;
      if (int'(dout) != exp_d || ^dout === 1'bx) begin
        n_err++; $display("[TB] FAIL rnd_dout@%0d: got %h expected %h", i, dout, exp_d);
      end
      n_cmp++;
      if (sel !== m_sel(adr)) begin
        n_err++; $display("[TB] FAIL rnd_sel@%0d: got %b expected %b", i, sel, m_sel(adr));
      end
      n_cmp++;
      if (irq !== 1'(m_irq)) begin
        n_err++; $display("[TB] FAIL rnd_irq@%0d: got %b expected %0d", i, irq, m_irq);
      end
    end
    nreset = 1'b1; tick = 1'b0; wr = 1'b0; rd = 1'b0; iack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div();
    test_overflow();
    test_iack();
    test_write_priority();
`ifdef TIMER_RELOAD_DELAY_EN
    test_cancel();
`endif
    test_div_write_edge();
    test_decode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
